// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtract engine: FSM encoding and default width.
package sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Encoding 2'd3 is unused; the controller steers it back to idle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d_c,
    output logic o_bout_c
);

    logic w_axb;

    assign w_axb    = i_a ^ i_b;
    assign o_d_c    = w_axb ^ i_bin;
    assign o_bout_c = (~i_a & i_b) | (~w_axb & i_bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtract controller: diff = a - b - borrow_in over WIDTH cycles, LSB first,
// reusing one full-subtractor cell with the borrow carried in a flop.
module serial_subtractor_ctrl
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_diff_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_brw;

    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_diff_next;

    full_subtractor u_fs (
        .i_a      (r_a_sr[0]),
        .i_b      (r_b_sr[0]),
        .i_bin    (r_brw),
        .o_d_c    (w_d),
        .o_bout_c (w_bout)
    );

    // New result bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    assign w_diff_next = {w_d, {(WIDTH-1){1'b0}}} | (r_diff_sr >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_a_sr     <= '0;
            r_b_sr     <= '0;
            r_diff_sr  <= '0;
            r_cnt      <= '0;
            r_brw      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_brw   <= borrow_in;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_a_sr    <= r_a_sr >> 1;
                    r_b_sr    <= r_b_sr >> 1;
                    r_diff_sr <= w_diff_next;
                    r_brw     <= w_bout;
                    if (r_cnt == CNT_LAST) begin
                        diff       <= w_diff_next;
                        borrow_out <= w_bout;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl: 8-bit directed vectors plus a 2-bit exhaustive sweep.
module tb_serial_subtractor_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       s8, bi8, busy8, done8, bo8;
    logic [7:0] a8, b8, diff8;
    logic       s2, bi2, busy2, done2, bo2;
    logic [1:0] a2, b2, diff2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] q8[$];
    logic [2:0] q2[$];

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .borrow_in(bi8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    serial_subtractor_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(s2), .a(a2), .b(b2), .borrow_in(bi2),
        .busy(busy2), .done(done2), .diff(diff2), .borrow_out(bo2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitors: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done8: got diff %0d borrow %0d, expected no done", diff8, bo8);
            end else begin
                logic [8:0] e;
                e = q8.pop_front();
                check("diff8", 32'(diff8), 32'(e[7:0]));
                check("borrow8", 32'(bo8), 32'(e[8]));
                check("busy_at_done8", 32'(busy8), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done2: got diff %0d borrow %0d, expected no done", diff2, bo2);
            end else begin
                logic [2:0] e;
                e = q2.pop_front();
                check("diff2", 32'(diff2), 32'(e[1:0]));
                check("borrow2", 32'(bo2), 32'(e[2]));
            end
        end
    end

    // Drive a one-cycle start on the 8-bit DUT; returns one negedge later.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input logic [7:0] ed, input logic eb, input bit push);
        s8 = 1'b1; a8 = a; b8 = b; bi8 = bin;
        if (push) q8.push_back({eb, ed});
        @(negedge clk);
        s8 = 1'b0;
    endtask

    // Counts negedges since the issuing negedge until done is seen, and busy-high samples before it.
    task automatic wait_done8(output int n, output int nbusy);
        n = 1;
        nbusy = 0;
        while (done8 !== 1'b1 && n < 40) begin
            if (busy8 === 1'b1) nbusy++;
            @(negedge clk);
            n++;
        end
        if (done8 !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout8: got no done after %0d cycles, expected done", n);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int n, nb;
        logic [2:0] m;
        rst = 1'b1;
        s8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;
        s2 = 1'b0; a2 = '0; b2 = '0; bi2 = 1'b0;
        idle(3);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_diff", 32'(diff8), 32'd0);
        check("rst_borrow", 32'(bo8), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic subtract, latency and busy width.
        issue8(8'd200, 8'd55, 1'b0, 8'd145, 1'b0, 1'b1);
        wait_done8(n, nb);
        check("latency", 32'(n), 32'd9);
        check("busy_cycles", 32'(nb), 32'd8);
        @(negedge clk);

        // Underflow cases.
        issue8(8'd5, 8'd10, 1'b0, 8'd251, 1'b1, 1'b1);
        wait_done8(n, nb);
        @(negedge clk);
        issue8(8'd0, 8'd0, 1'b1, 8'd255, 1'b1, 1'b1);
        wait_done8(n, nb);
        check("latency_bin", 32'(n), 32'd9);
        @(negedge clk);

        // Start during SHIFT is ignored.
        issue8(8'd9, 8'd4, 1'b0, 8'd5, 1'b0, 1'b1);
        idle(2);
        s8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
        @(negedge clk);
        s8 = 1'b0;
        wait_done8(n, nb);
        idle(12);

        // Reset during the fourth SHIFT cycle aborts without done.
        issue8(8'd7, 8'd3, 1'b0, 8'd0, 1'b0, 1'b0);
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_diff", 32'(diff8), 32'd0);
        check("abort_borrow", 32'(bo8), 32'd0);
        idle(12);
        issue8(8'd77, 8'd33, 1'b1, 8'd43, 1'b0, 1'b1);
        wait_done8(n, nb);
        check("latency_after_abort", 32'(n), 32'd9);
        @(negedge clk);

        // Start held high: back-to-back results every 9 cycles.
        s8 = 1'b1; a8 = 8'd100; b8 = 8'd30; bi8 = 1'b0;
        q8.push_back({1'b0, 8'd70});
        @(negedge clk);
        wait_done8(n, nb);
        check("b2b_first", 32'(n), 32'd9);
        a8 = 8'd30; b8 = 8'd100; bi8 = 1'b0;
        q8.push_back({1'b1, 8'd186});
        @(negedge clk);
        wait_done8(n, nb);
        check("b2b_gap1", 32'(n), 32'd9);
        a8 = 8'd255; b8 = 8'd255; bi8 = 1'b1;
        q8.push_back({1'b1, 8'd255});
        @(negedge clk);
        wait_done8(n, nb);
        check("b2b_gap2", 32'(n), 32'd9);
        a8 = 8'd128; b8 = 8'd1; bi8 = 1'b1;
        q8.push_back({1'b0, 8'd126});
        @(negedge clk);
        wait_done8(n, nb);
        check("b2b_gap3", 32'(n), 32'd9);
        s8 = 1'b0;
        idle(12);

        // WIDTH=2 exhaustive sweep against {borrow, diff} = a - b - bin.
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    m = 3'(ia) - 3'(ib) - 3'(ic);
                    s2 = 1'b1; a2 = 2'(ia); b2 = 2'(ib); bi2 = 1'(ic);
                    q2.push_back(m);
                    @(negedge clk);
                    s2 = 1'b0;
                    n = 1;
                    while (done2 !== 1'b1 && n < 20) begin
                        @(negedge clk);
                        n++;
                    end
                    check("latency2", 32'(n), 32'd3);
                    @(negedge clk);
                end
            end
        end
        idle(5);

        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
